// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: walks NUM_CH channel words onto one 7-segment path,
// blanking the start of every slot, with per-digit mask, scan hold and manual channel select.
module display_scan_mux #(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int DIV           = 1000,
  parameter int BLANK         = 16,
  parameter int EN_ACTIVE_LOW = 0,
  localparam int CW           = $clog2(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]       i_mask,
  input  logic                    i_hold,
  input  logic                    i_manual,
  input  logic [CW-1:0]           i_ctrl,
  output logic [WIDTH-1:0]        o_data,
  output logic [NUM_CH-1:0]       o_digit_en,
  output logic [CW-1:0]           o_sel,
  output logic                    o_frame
);

  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] CNT_BLANK = CNTW'(BLANK);
  localparam logic [CW-1:0]   SEL_LAST  = CW'(NUM_CH - 1);
  localparam logic            EN_INACT  = (EN_ACTIVE_LOW != 0);

  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]     sel_q, sel_d;
  logic              manual_q;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              frame_q, frame_d;
  logic              show;

  // Manual wins over hold; the first auto edge after manual restarts the slot in blanking.
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    frame_d = 1'b0;
    if (i_manual) begin
      cnt_d = CNT_BLANK;
      sel_d = i_ctrl;
    end else if (manual_q) begin
      cnt_d = '0;
    end else if (!i_hold) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (sel_q == SEL_LAST) begin
          sel_d   = '0;
          frame_d = 1'b1;
        end else begin
          sel_d = sel_q + CW'(1);
        end
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as cnt/sel.
  // An out-of-range index matches no channel and therefore stays blank.
  always_comb begin
    data_d = '0;
    en_d   = '0;
    show   = (cnt_d >= CNT_BLANK);
    for (int k = 0; k < NUM_CH; k++) begin
      if (show && i_mask[k] && (sel_d == CW'(k))) begin
        data_d  = i_data[k*WIDTH +: WIDTH];
        en_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      sel_q    <= '0;
      manual_q <= 1'b0;
      data_q   <= '0;
      en_q     <= {NUM_CH{EN_INACT}};
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      manual_q <= i_manual;
      data_q   <= data_d;
      en_q     <= en_d ^ {NUM_CH{EN_INACT}};
      frame_q  <= frame_d;
    end
  end

  assign o_data     = data_q;
  assign o_digit_en = en_q;
  assign o_sel      = sel_q;
  assign o_frame    = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural slot/channel model.
module tb_display_scan_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dataBus = 32'h04030201;
  logic [3:0]  mask = 4'b1111;
  logic        hold = 1'b0;
  logic        manual = 1'b0;
  logic [1:0]  ctrl = 2'd0;
  logic [7:0]  oData;
  logic [3:0]  oEn;
  logic [1:0]  oSel;
  logic        oFrame;

  int checks = 0;
  int errors = 0;
  int curCycle = 0;

  display_scan_mux #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DIV(DIV), .BLANK(BLANK), .EN_ACTIVE_LOW(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_data(dataBus), .i_mask(mask), .i_hold(hold),
    .i_manual(manual), .i_ctrl(ctrl), .o_data(oData), .o_digit_en(oEn),
    .o_sel(oSel), .o_frame(oFrame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         pos;
    int         chan;
    logic       wasMan;
    logic [7:0] data;
    logic [3:0] en;
    logic [1:0] sel;
    logic       frame;
  } model_t;

  model_t m;

  // Position within the slot and current channel as plain integers; outputs follow from them.
  function automatic model_t stepModel(model_t s, logic man, logic hld, logic [1:0] ct,
                                       logic [3:0] mk, logic [31:0] db);
    model_t n;
    int p, c;
    logic lit, f;
    n = '0;
    p = s.pos;
    c = s.chan;
    f = 1'b0;
    if (man) begin
      p = BLANK;
      c = int'(ct);
    end else if (s.wasMan) begin
      p = 0;
    end else if (!hld) begin
      p = p + 1;
      if (p == DIV) begin
        p = 0;
        c = c + 1;
        if (c == NUM_CH) begin
          c = 0;
          f = 1'b1;
        end
      end
    end
    lit      = (p >= BLANK) && mk[c];
    n.pos    = p;
    n.chan   = c;
    n.wasMan = man;
    n.sel    = 2'(c);
    n.data   = lit ? db[c*WIDTH +: WIDTH] : 8'h00;
    n.en     = lit ? 4'(1 << c) : 4'b0000;
    n.frame  = f;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= stepModel(m, manual, hold, ctrl, mask, dataBus);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the rising edge.
  always @(negedge clk) begin
    checkOutput("model o_data", 32'(oData), 32'(m.data));
    checkOutput("model o_digit_en", 32'(oEn), 32'(m.en));
    checkOutput("model o_sel", 32'(oSel), 32'(m.sel));
    checkOutput("model o_frame", 32'(oFrame), 32'(m.frame));
  end

  task automatic goToCycle(input int target);
    while (curCycle < target) begin
      @(negedge clk);
      curCycle++;
    end
  endtask

  // Literal expectations checked against both the DUT and the model.
  task automatic expectAt(input int cyc, input string name, input logic [7:0] d,
                          input logic [3:0] en, input logic [1:0] sel);
    goToCycle(cyc);
    checkOutput({name, " data"}, 32'(oData), 32'(d));
    checkOutput({name, " en"}, 32'(oEn), 32'(en));
    checkOutput({name, " sel"}, 32'(oSel), 32'(sel));
    checkOutput({name, " model data"}, 32'(m.data), 32'(d));
    checkOutput({name, " model en"}, 32'(m.en), 32'(en));
  endtask

  task automatic expectFrame(input int cyc, input string name, input logic f);
    goToCycle(cyc);
    checkOutput({name, " frame"}, 32'(oFrame), 32'(f));
    checkOutput({name, " model frame"}, 32'(m.frame), 32'(f));
  endtask

  task automatic applyStimulus(input logic man, input logic hld, input logic [1:0] ct,
                               input logic [3:0] mk);
    manual = man;
    hold   = hld;
    ctrl   = ct;
    mask   = mk;
  endtask

  task automatic doReset(input int edges, input logic [3:0] mk);
    @(negedge clk);
    rst = 1'b1;
    dataBus = 32'h04030201;
    applyStimulus(1'b0, 1'b0, 2'd0, mk);
    repeat (edges) @(negedge clk);
    checkOutput("in reset data", 32'(oData), 32'h0);
    checkOutput("in reset en", 32'(oEn), 32'h0);
    checkOutput("in reset sel", 32'(oSel), 32'h0);
    checkOutput("in reset frame", 32'(oFrame), 32'h0);
    rst = 1'b0;
    curCycle = 0;
  endtask

  initial begin
    #1 rst = 1'b1;

    // Reset and first slot, then a full frame
    doReset(3, 4'b1111);
    expectAt(0, "c0 blank", 8'h00, 4'b0000, 2'd0);
    expectAt(1, "c1 blank", 8'h00, 4'b0000, 2'd0);
    expectAt(2, "c2 lit", 8'h01, 4'b0001, 2'd0);
    expectAt(7, "c7 lit", 8'h01, 4'b0001, 2'd0);
    expectAt(8, "c8 next slot blank", 8'h00, 4'b0000, 2'd1);
    expectAt(10, "slot1 lit", 8'h02, 4'b0010, 2'd1);
    expectAt(18, "slot2 lit", 8'h03, 4'b0100, 2'd2);
    expectAt(26, "slot3 lit", 8'h04, 4'b1000, 2'd3);
    expectFrame(31, "c31", 1'b0);
    expectFrame(32, "c32 wrap", 1'b1);
    expectAt(32, "c32", 8'h00, 4'b0000, 2'd0);
    expectFrame(33, "c33", 1'b0);
    goToCycle(40);

    // Mask out digit 2
    doReset(2, 4'b1011);
    expectAt(18, "masked slot2", 8'h00, 4'b0000, 2'd2);
    expectAt(23, "masked slot2 end", 8'h00, 4'b0000, 2'd2);
    expectAt(25, "slot3 blank", 8'h00, 4'b0000, 2'd3);
    expectAt(26, "slot3 lit after mask", 8'h04, 4'b1000, 2'd3);
    expectAt(31, "slot3 last", 8'h04, 4'b1000, 2'd3);

    // Manual select, then return to auto
    doReset(2, 4'b1111);
    goToCycle(5);
    applyStimulus(1'b1, 1'b0, 2'd2, 4'b1111);
    expectAt(6, "manual ch2", 8'h03, 4'b0100, 2'd2);
    expectAt(9, "manual ch2 steady", 8'h03, 4'b0100, 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd3, 4'b1111);
    expectAt(10, "manual ch3", 8'h04, 4'b1000, 2'd3);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'b1111);
    expectAt(11, "leave manual blank0", 8'h00, 4'b0000, 2'd3);
    expectAt(12, "leave manual blank1", 8'h00, 4'b0000, 2'd3);
    expectAt(13, "leave manual lit", 8'h04, 4'b1000, 2'd3);
    expectAt(18, "leave manual lit end", 8'h04, 4'b1000, 2'd3);
    expectAt(19, "after manual wrap", 8'h00, 4'b0000, 2'd0);
    expectFrame(19, "after manual wrap", 1'b1);

    // Hold while channel 0 changes
    doReset(2, 4'b1111);
    expectAt(4, "pre hold", 8'h01, 4'b0001, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111);
    dataBus = 32'h040302AA;
    expectAt(5, "hold new data", 8'hAA, 4'b0001, 2'd0);
    expectAt(24, "hold end", 8'hAA, 4'b0001, 2'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'b1111);
    expectAt(27, "post hold last", 8'hAA, 4'b0001, 2'd0);
    expectAt(28, "post hold next slot", 8'h00, 4'b0000, 2'd1);

    // Asynchronous reset mid-slot
    doReset(2, 4'b1111);
    expectAt(12, "slot1 before rst", 8'h02, 4'b0010, 2'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async rst data", 32'(oData), 32'h0);
    checkOutput("async rst en", 32'(oEn), 32'h0);
    checkOutput("async rst sel", 32'(oSel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    curCycle = 0;
    expectAt(0, "restart blank", 8'h00, 4'b0000, 2'd0);
    expectAt(2, "restart lit", 8'h01, 4'b0001, 2'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) dataBus = $urandom;
      if ($urandom_range(15) == 0) mask = 4'($urandom);
      ctrl = 2'($urandom);
      if (manual) begin
        if ($urandom_range(5) == 0) manual = 1'b0;
      end else if ($urandom_range(39) == 0) begin
        manual = 1'b1;
      end
      if (hold) begin
        if ($urandom_range(3) == 0) hold = 1'b0;
      end else if ($urandom_range(29) == 0) begin
        hold = 1'b1;
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
